video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
// Parametrised display timing generator: H/V raster counters, sync/DE generation, centred
// frame-buffer read window and a configurable sync-alignment delay line. Sits between the
// HDMI pixel clock domain and the frame-buffer readout / TMDS encoder. Replaces the fixed
// sync generator plus hand-written 5-stage hs/vs/de delay with a single generalised block.
// PARAMETERS
// H_TOTAL 1056 | H_SYNC 128 | H_BPORCH 88 | H_RES 800: horizontal timing, pixel clocks
// V_TOTAL 628  | V_SYNC 4   | V_BPORCH 23 | V_RES 600: vertical timing, lines
// RD_HRES 640, RD_VRES 480: read window size, centred in active area
// HS_POL 1, VS_POL 1: sync polarity (1 = active-high)
// DLY 5: stages between o_rden and o_hs/o_vs/o_de (1..16), matches buffer read latency
// XW = $clog2(RD_HRES), YW = $clog2(RD_VRES): coordinate widths (derived localparams)
// PORTS
// iclk      in   1   pixel clock
// irst      in   1   synchronous reset, active-high
// i_en      in   1   run enable; low = raster held at origin
// o_rden    out  1   read-window strobe to frame buffer (stage 0)
// o_rd_sof  out  1   1-cycle pulse with first o_rden of each frame (stage 0)
// o_hs      out  1   horizontal sync, polarity HS_POL (stage DLY)
// o_vs      out  1   vertical sync, polarity VS_POL (stage DLY)
// o_de      out  1   active-area data enable (stage DLY)
// o_win     out  1   read-window valid, aligned with o_de (stage DLY)
// o_x       out  XW  window column, 0 when o_win=0 (stage DLY)
// o_y       out  YW  window row, 0 when o_win=0 (stage DLY)
// o_sof     out  1   1-cycle pulse at raster (0,0) (stage DLY)
// BEHAVIOUR
// - Reset: h=v=0, vfsm=VSYNC, all pipe stages inactive; o_hs=~HS_POL, o_vs=~VS_POL, all else 0.
// - h counts 0..H_TOTAL-1 each cycle while i_en; wrap -> 0 and advance line. Line
//   V_TOTAL-1 wraps to 0 (frame wrap) on the same cycle as h wrap.
// - Vertical FSM: VSYNC(V_SYNC lines) -> VBP(V_BPORCH) -> VACT(V_RES) -> VFP(rest) -> VSYNC;
//   transitions only at h=H_TOTAL-1. v_line counter reset on each state entry.
// - Raw: hs = h<H_SYNC; vs = state VSYNC; de = h in [H_SYNC+H_BPORCH, +H_RES) && VACT.
// - Window: X0=H_SYNC+H_BPORCH+(H_RES-RD_HRES)/2, Y0=(V_RES-RD_VRES)/2 (floor division);
//   win = h in [X0,X0+RD_HRES) && VACT line in [Y0,Y0+RD_VRES).
// - Stage 0 registers raw signals one cycle after counter state; o_rden/o_rd_sof = stage 0.
// - o_hs/o_vs/o_de/o_win/o_x/o_y/o_sof = stage 0 delayed DLY cycles (o_de lags o_rden by DLY).
// - Polarity applied at output: o_hs = hs ^ ~HS_POL, same for vs.
// - i_en low: counters forced to 0/VSYNC next cycle, stage-0 input forced inactive; pipe
//   keeps shifting so outputs drain to inactive within DLY cycles. i_en rise: new frame
//   from (0,0), o_sof fires DLY+1 cycles later. Mid-frame drop/restart allowed.
// - Reset mid-frame: all state and pipe cleared in one cycle, no partial pulses afterwards.
// - Elaboration $error if H_SYNC+H_BPORCH+H_RES>H_TOTAL, same for V, RD_*>*_RES, DLY out of range.
// STRUCTURE
// - Shared package canny_video_pkg: vfsm state enum (VSYNC,VBP,VACT,VFP), timing presets
//   800x600 / 1024x768 / 1280x720 as localparams.
// - Sub-module pipe_delay #(W,DEPTH): generic synchronous-reset shift register, instantiated
//   once for the packed {hs,vs,de,win,x,y,sof} bus.
// TESTING (small params: H 16/2/2/8, V 8/1/1/4, RD 4x2, DLY 3, pols 1)
// 1. Reset 5 cycles, i_en=1 -> o_hs=0,o_vs=0 during reset; o_sof at cycle 4 after release,
//    then every 128 cycles; o_hs high 2 cycles per 16.
// 2. Window: o_rden high for h=6..9 on lines 3,4 only (8 per frame); o_de high 8/line on
//    lines 2..5; o_win rises exactly 3 cycles after o_rden, o_x 0..3, o_y 0..1.
// 3. HS_POL=0,VS_POL=0 -> o_hs low 2 of 16 cycles, o_vs low for line 0 only; de unchanged.
// 4. Drop i_en mid-line 3 -> o_rden 0 next cycle, outputs inactive within 3 cycles; re-raise
//    -> o_sof after 4 cycles, full frame identical to scenario 2.
// 5. Assert irst during line 4 window -> next cycle all outputs at reset values, no o_win glitch.
// 6. Default 800x600 params: 1056*628 cycles per o_sof, 640*480 o_rden cycles per frame.

Source files
------------

// File: rtl/canny_video_pkg.sv
// canny_video_pkg: shared vertical FSM state type, standard timing presets and width helper.
package canny_video_pkg;

    typedef enum logic [1:0] {VSYNC = 2'd0, VBP = 2'd1, VACT = 2'd2, VFP = 2'd3} vfsm_t;

    localparam int P800_H_TOTAL  = 1056;
    localparam int P800_H_SYNC   = 128;
    localparam int P800_H_BPORCH = 88;
    localparam int P800_H_RES    = 800;
    localparam int P800_V_TOTAL  = 628;
    localparam int P800_V_SYNC   = 4;
    localparam int P800_V_BPORCH = 23;
    localparam int P800_V_RES    = 600;

    localparam int P1024_H_TOTAL  = 1344;
    localparam int P1024_H_SYNC   = 136;
    localparam int P1024_H_BPORCH = 160;
    localparam int P1024_H_RES    = 1024;
    localparam int P1024_V_TOTAL  = 806;
    localparam int P1024_V_SYNC   = 6;
    localparam int P1024_V_BPORCH = 29;
    localparam int P1024_V_RES    = 768;

    localparam int P720_H_TOTAL  = 1650;
    localparam int P720_H_SYNC   = 40;
    localparam int P720_H_BPORCH = 220;
    localparam int P720_H_RES    = 1280;
    localparam int P720_V_TOTAL  = 750;
    localparam int P720_V_SYNC   = 5;
    localparam int P720_V_BPORCH = 20;
    localparam int P720_V_RES    = 720;

    // $clog2 that never yields a zero-width vector
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// pipe_delay: generic DEPTH-stage shift register with synchronous reset.
module pipe_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_sr [DEPTH];
    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end
    assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, sync/DE, centred read window and sync-alignment delay line.
module video_timing_gen import canny_video_pkg::*; #(
    parameter int H_TOTAL  = 1056,
    parameter int H_SYNC   = 128,
    parameter int H_BPORCH = 88,
    parameter int H_RES    = 800,
    parameter int V_TOTAL  = 628,
    parameter int V_SYNC   = 4,
    parameter int V_BPORCH = 23,
    parameter int V_RES    = 600,
    parameter int RD_HRES  = 640,
    parameter int RD_VRES  = 480,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int DLY      = 5,
    localparam int XW      = cw(RD_HRES),
    localparam int YW      = cw(RD_VRES)
) (
    input  logic          iclk,
    input  logic          irst,
    input  logic          i_en,
    output logic          o_rden,
    output logic          o_rd_sof,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_de,
    output logic          o_win,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_sof
);
    localparam int HW   = $clog2(H_TOTAL + 1);
    localparam int LW   = $clog2(V_TOTAL + 1);
    localparam int HA0  = H_SYNC + H_BPORCH;
    localparam int X0   = HA0 + (H_RES - RD_HRES) / 2;
    localparam int Y0   = (V_RES - RD_VRES) / 2;
    localparam int V_FP = V_TOTAL - V_SYNC - V_BPORCH - V_RES;
    localparam int PW   = 5 + XW + YW;

    if (H_SYNC + H_BPORCH + H_RES > H_TOTAL) begin : g_chk_h
        $error("horizontal timing exceeds H_TOTAL");
    end
    if (V_SYNC + V_BPORCH + V_RES > V_TOTAL) begin : g_chk_v
        $error("vertical timing exceeds V_TOTAL");
    end
    if (RD_HRES > H_RES || RD_VRES > V_RES) begin : g_chk_rd
        $error("read window larger than active area");
    end
    if (DLY < 1 || DLY > 16) begin : g_chk_dly
        $error("DLY must be 1..16");
    end

    logic [HW-1:0] r_h, w_h_nxt;
    logic [LW-1:0] r_line, w_line_nxt, w_last;
    vfsm_t         r_state, w_state_nxt;
    logic          w_hend, w_lend;

    assign w_hend = r_h == HW'(H_TOTAL - 1);
    assign w_last = (r_state == VSYNC) ? LW'(V_SYNC - 1) :
                    (r_state == VBP)   ? LW'(V_BPORCH - 1) :
                    (r_state == VACT)  ? LW'(V_RES - 1) : LW'(V_FP - 1);
    assign w_lend = r_line == w_last;

    // disabled raster parks at the origin so the next enable starts a fresh frame
    always_comb begin
        w_h_nxt     = '0;
        w_line_nxt  = '0;
        w_state_nxt = VSYNC;
        if (i_en) begin
            w_h_nxt     = w_hend ? '0 : r_h + 1'b1;
            w_line_nxt  = r_line;
            w_state_nxt = r_state;
            if (w_hend) begin
                w_line_nxt = w_lend ? '0 : r_line + 1'b1;
                if (w_lend)
                    w_state_nxt = (r_state == VACT && V_FP == 0) ? VSYNC : vfsm_t'(r_state + 2'd1);
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_h     <= '0;
            r_line  <= '0;
            r_state <= VSYNC;
        end else begin
            r_h     <= w_h_nxt;
            r_line  <= w_line_nxt;
            r_state <= w_state_nxt;
        end
    end

    logic          w_hs, w_vs, w_de, w_win, w_sof, w_rd_sof, w_vact;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;

    assign w_vact   = r_state == VACT;
    assign w_hs     = r_h < HW'(H_SYNC);
    assign w_vs     = r_state == VSYNC;
    assign w_de     = w_vact && r_h >= HW'(HA0) && r_h < HW'(HA0 + H_RES);
    assign w_win    = w_vact && r_h >= HW'(X0) && r_h < HW'(X0 + RD_HRES)
                      && r_line >= LW'(Y0) && r_line < LW'(Y0 + RD_VRES);
    assign w_x      = w_win ? XW'(r_h - HW'(X0)) : '0;
    assign w_y      = w_win ? YW'(r_line - LW'(Y0)) : '0;
    assign w_sof    = w_vs && r_h == '0 && r_line == '0;
    assign w_rd_sof = w_win && r_h == HW'(X0) && r_line == LW'(Y0);

    logic [PW-1:0] r_s0, w_q;
    logic          r_rd_sof;

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_s0     <= '0;
            r_rd_sof <= 1'b0;
        end else begin
            r_s0     <= i_en ? {w_hs, w_vs, w_de, w_win, w_x, w_y, w_sof} : '0;
            r_rd_sof <= i_en && w_rd_sof;
        end
    end

    assign o_rden   = r_s0[PW-4];
    assign o_rd_sof = r_rd_sof;

    pipe_delay #(.W(PW), .DEPTH(DLY)) u_pipe (
        .iclk (iclk),
        .irst (irst),
        .i_d  (r_s0),
        .o_q  (w_q)
    );

    logic w_hs_q, w_vs_q;
    assign {w_hs_q, w_vs_q, o_de, o_win, o_x, o_y, o_sof} = w_q;
    assign o_hs = w_hs_q ^ ~HS_POL;
    assign o_vs = w_vs_q ^ ~VS_POL;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized enable/reset stimulus checked every cycle against a raster-position model.
module tb_video_timing_gen;
    localparam int HT = 16, HS = 2, HBP = 2, HR = 8;
    localparam int VT = 8, VS = 1, VBP = 1, VR = 4;
    localparam int RDH = 4, RDV = 2, DLY = 3;
    localparam int HA = HS + HBP, VA = VS + VBP;
    localparam int X0 = HA + (HR - RDH) / 2, Y0A = VA + (VR - RDV) / 2;

    logic clk = 1'b0, rst = 1'b1, en = 1'b1;
    always #5 clk = ~clk;

    logic o_rden_a, o_rd_sof_a, o_hs_a, o_vs_a, o_de_a, o_win_a, o_sof_a;
    logic o_rden_b, o_rd_sof_b, o_hs_b, o_vs_b, o_de_b, o_win_b, o_sof_b;
    logic [1:0] o_x_a, o_x_b;
    logic [0:0] o_y_a, o_y_b;

    video_timing_gen #(.H_TOTAL(HT), .H_SYNC(HS), .H_BPORCH(HBP), .H_RES(HR),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BPORCH(VBP), .V_RES(VR), .RD_HRES(RDH), .RD_VRES(RDV),
        .HS_POL(1'b1), .VS_POL(1'b1), .DLY(DLY)) dut_a (
        .iclk(clk), .irst(rst), .i_en(en), .o_rden(o_rden_a), .o_rd_sof(o_rd_sof_a),
        .o_hs(o_hs_a), .o_vs(o_vs_a), .o_de(o_de_a), .o_win(o_win_a), .o_x(o_x_a),
        .o_y(o_y_a), .o_sof(o_sof_a));

    video_timing_gen #(.H_TOTAL(HT), .H_SYNC(HS), .H_BPORCH(HBP), .H_RES(HR),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BPORCH(VBP), .V_RES(VR), .RD_HRES(RDH), .RD_VRES(RDV),
        .HS_POL(1'b0), .VS_POL(1'b0), .DLY(DLY)) dut_b (
        .iclk(clk), .irst(rst), .i_en(en), .o_rden(o_rden_b), .o_rd_sof(o_rd_sof_b),
        .o_hs(o_hs_b), .o_vs(o_vs_b), .o_de(o_de_b), .o_win(o_win_b), .o_x(o_x_b),
        .o_y(o_y_b), .o_sof(o_sof_b));

    int vectors = 0, miscompares = 0;
    bit chk_on = 0;

    task automatic chk(input string n, input int a, input int e);
        vectors++;
        if (a != e) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    typedef struct {bit hs, vs, de, win, sof, rdsof; int x, y;} st_t;
    st_t hist[DLY+1];
    int mh = 0, mv = 0;

    function automatic st_t zst();
        st_t s = '{default: 0};
        return s;
    endfunction

    // expected raw signals from absolute raster position (h, frame line)
    function automatic st_t raw(input int h, input int v);
        st_t s;
        s.hs    = h < HS;
        s.vs    = v < VS;
        s.de    = h >= HA && h < HA + HR && v >= VA && v < VA + VR;
        s.win   = h >= X0 && h < X0 + RDH && v >= Y0A && v < Y0A + RDV;
        s.x     = s.win ? h - X0 : 0;
        s.y     = s.win ? v - Y0A : 0;
        s.sof   = h == 0 && v == 0;
        s.rdsof = s.win && h == X0 && v == Y0A;
        return s;
    endfunction

    always @(posedge clk) begin
        for (int k = DLY; k > 0; k--) hist[k] = rst ? zst() : hist[k-1];
        hist[0] = (rst || !en) ? zst() : raw(mh, mv);
        if (rst || !en) begin
            mh = 0;
            mv = 0;
        end else if (mh == HT - 1) begin
            mh = 0;
            mv = (mv + 1) % VT;
        end else mh++;
    end

    always @(negedge clk) if (chk_on) begin
        chk("rden_a",   int'(o_rden_a),   int'(hist[0].win));
        chk("rd_sof_a", int'(o_rd_sof_a), int'(hist[0].rdsof));
        chk("hs_a",     int'(o_hs_a),     int'(hist[DLY].hs));
        chk("vs_a",     int'(o_vs_a),     int'(hist[DLY].vs));
        chk("de_a",     int'(o_de_a),     int'(hist[DLY].de));
        chk("win_a",    int'(o_win_a),    int'(hist[DLY].win));
        chk("x_a",      int'(o_x_a),      hist[DLY].x);
        chk("y_a",      int'(o_y_a),      hist[DLY].y);
        chk("sof_a",    int'(o_sof_a),    int'(hist[DLY].sof));
        chk("rden_b",   int'(o_rden_b),   int'(hist[0].win));
        chk("hs_b",     int'(o_hs_b),     int'(!hist[DLY].hs));
        chk("vs_b",     int'(o_vs_b),     int'(!hist[DLY].vs));
        chk("de_b",     int'(o_de_b),     int'(hist[DLY].de));
        chk("win_b",    int'(o_win_b),    int'(hist[DLY].win));
        chk("sof_b",    int'(o_sof_b),    int'(hist[DLY].sof));
    end

    int c_rden, c_de, c_hs, c_vs, c_win, c_sof, c_rdsof, c_hsb, c_vsb, c_deb, mx, my;

    task automatic count_cycles(input int n);
        {c_rden, c_de, c_hs, c_vs, c_win, c_sof, c_rdsof, c_hsb, c_vsb, c_deb, mx, my} = '0;
        repeat (n) begin
            @(posedge clk); #1;
            c_rden += int'(o_rden_a);
            c_de += int'(o_de_a);
            c_hs += int'(o_hs_a);
            c_vs += int'(o_vs_a);
            c_win += int'(o_win_a);
            c_sof += int'(o_sof_a);
            c_rdsof += int'(o_rd_sof_a);
            c_hsb += int'(!o_hs_b);
            c_vsb += int'(!o_vs_b);
            c_deb += int'(o_de_b);
            if (o_win_a && int'(o_x_a) > mx) mx = int'(o_x_a);
            if (o_win_a && int'(o_y_a) > my) my = int'(o_y_a);
        end
    endtask

    task automatic wait_sof(output int t);
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!o_sof_a && t < 300);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk); #2;
        chk_on = 1;
        @(negedge clk); #1;
        chk("reset_hs_a", int'(o_hs_a), 0);
        chk("reset_vs_a", int'(o_vs_a), 0);
        chk("reset_hs_b", int'(o_hs_b), 1);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        wait_sof(t);
        chk("sof_latency", t, 4);
        count_cycles(128);
        chk("sof_period", int'(o_sof_a), 1);
        chk("sof_per_frame", c_sof, 1);
        chk("rden_per_frame", c_rden, 8);
        chk("rd_sof_per_frame", c_rdsof, 1);
        chk("de_per_frame", c_de, 32);
        chk("win_per_frame", c_win, 8);
        chk("hs_high_per_frame", c_hs, 16);
        chk("vs_high_per_frame", c_vs, 16);
        chk("x_max", mx, 3);
        chk("y_max", my, 1);
        chk("hs_b_low_per_frame", c_hsb, 16);
        chk("vs_b_low_per_frame", c_vsb, 16);
        chk("de_b_per_frame", c_deb, 32);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            en  = $urandom_range(0, 15) != 0;
            rst = $urandom_range(0, 199) == 0;
        end

        @(posedge clk); #2;
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!o_rden_a && t < 300);
        chk("rden_seen", int'(o_rden_a), 1);
        #1 en = 1'b0;
        @(posedge clk); #1;
        chk("drop_rden", int'(o_rden_a), 0);
        repeat (DLY) @(posedge clk);
        #1;
        chk("drop_de", int'(o_de_a), 0);
        chk("drop_win", int'(o_win_a), 0);
        chk("drop_hs", int'(o_hs_a), 0);
        chk("drop_vs", int'(o_vs_a), 0);
        #1 en = 1'b1;
        wait_sof(t);
        chk("restart_sof_latency", t, 4);
        count_cycles(128);
        chk("restart_rden", c_rden, 8);
        chk("restart_de", c_de, 32);
        chk("restart_sof", c_sof, 1);

        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!(o_win_a && o_y_a == 1'b1) && t < 300);
        chk("line4_win_seen", int'(o_win_a && o_y_a == 1'b1), 1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_win", int'(o_win_a), 0);
        chk("rst_rden", int'(o_rden_a), 0);
        chk("rst_de", int'(o_de_a), 0);
        chk("rst_hs_a", int'(o_hs_a), 0);
        chk("rst_hs_b", int'(o_hs_b), 1);
        chk("rst_vs_b", int'(o_vs_b), 1);
        chk("rst_x", int'(o_x_a), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
